// File: rtl/carrd_pkg.sv
// ---------------------------------------------------------------------------
// carrd_pkg
// Shared types and constants for the CARRD writeback sequencer.
//   VLANE_W      : width of one vector writeback beat (128 bits)
//   NBEATS_MAX   : beats carried by one vector writeback request (4)
//   wb_state_e   : drain FSM states (IDLE / DRAIN)
//   wb_entry_t   : one queued vector request {dest, clamped nbeats, 4 beats}
//   clampNbeats  : maps a raw 3-bit beat count into the legal 1..4 range
// ---------------------------------------------------------------------------
package carrd_pkg;

    localparam int VLANE_W    = 128;
    localparam int NBEATS_MAX = 4;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } wb_state_e;

    // Beat 0 lives at data[0]; the head entry is indexed directly by the
    // drain FSM's beat counter.
    typedef struct packed {
        logic [4:0]                         dest;
        logic [2:0]                         nbeats;
        logic [NBEATS_MAX-1:0][VLANE_W-1:0] data;
    } wb_entry_t;

    // A zero count still means one beat; anything above 4 saturates.
    function automatic logic [2:0] clampNbeats(input logic [2:0] raw);
        logic [2:0] result;
        if (raw == 3'd0) begin
            result = 3'd1;
        end else if (raw > 3'd4) begin
            result = 3'd4;
        end else begin
            result = raw;
        end
        return result;
    endfunction

endpackage

// File: rtl/carrd_wb_fifo.sv
// ---------------------------------------------------------------------------
// carrd_wb_fifo
// Parameterized synchronous FIFO of wb_entry_t used to queue vector
// writeback requests ahead of the VRF drain FSM.
//   clk        : clock, all state changes on rising edge
//   nrst       : synchronous active-low reset, empties the queue
//   i_push     : write i_pushData (ignored while full)
//   i_pushData : entry to enqueue
//   i_pop      : discard the head entry (ignored while empty)
//   o_head     : current head entry (valid when !o_empty)
//   o_full     : DEPTH entries held
//   o_empty    : no entries held
//   o_single   : exactly one entry held
// ---------------------------------------------------------------------------
module carrd_wb_fifo
    import carrd_pkg::*;
#(
    parameter int DEPTH = 2
)(
    input  logic      clk,
    input  logic      nrst,
    input  logic      i_push,
    input  wb_entry_t i_pushData,
    input  logic      i_pop,
    output wb_entry_t o_head,
    output logic      o_full,
    output logic      o_empty,
    output logic      o_single
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    wb_entry_t        r_mem [DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [CNT_W-1:0] r_count;

    logic w_doPush;
    logic w_doPop;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] ptr);
        logic [PTR_W-1:0] result;
        if (ptr == PTR_W'(DEPTH - 1)) begin
            result = '0;
        end else begin
            result = ptr + PTR_W'(1);
        end
        return result;
    endfunction

    assign o_full   = (r_count == CNT_W'(DEPTH));
    assign o_empty  = (r_count == '0);
    assign o_single = (r_count == CNT_W'(1));
    assign w_doPush = i_push & ~o_full;
    assign w_doPop  = i_pop & ~o_empty;
    assign o_head   = r_mem[r_rdPtr];

    // Storage needs no reset: an empty count makes stale contents invisible.
    always_ff @(posedge clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= i_pushData;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= nextPtr(r_wrPtr);
            end
            if (w_doPop) begin
                r_rdPtr <= nextPtr(r_rdPtr);
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/carrd_wb_sequencer.sv
// ---------------------------------------------------------------------------
// carrd_wb_sequencer
// Splits multi-beat vector writebacks into single-beat VRF writes and
// forwards scalar writebacks straight to the XRF.
//
// Parameters
//   FIFO_DEPTH : queued vector requests (2..8)
//   XLEN       : scalar register width
//
// Ports
//   clk, nrst            : clock / synchronous active-low reset
//   v_reg_wr_en          : vector request level (rising edge = new request)
//   x_reg_wr_en          : scalar request level (rising edge = new request)
//   wb_dest, wb_nbeats   : base register index and beat count (1..4)
//   reg_wr_data[_2.._4]  : beats 0..3
//   vrf_wr_gnt           : VRF write port accept
//   vrf_wr_en/addr/data  : single-beat VRF write port
//   xrf_wr_en/addr/data  : one-cycle scalar write pulse
//   wb_ready             : request FIFO not full
//   wb_busy              : any vector work queued or draining
//   wb_ovf               : sticky, a request arrived while full
//   wb_pending           : per-register outstanding-write mask
//
// Build option
//   CARRD_WB_PENDING_EN  : when defined, wb_pending is driven by a
//                          per-register scoreboard; otherwise it is tied 0.
// ---------------------------------------------------------------------------
module carrd_wb_sequencer
    import carrd_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int XLEN       = 32
)(
    input  logic               clk,
    input  logic               nrst,
    input  logic               v_reg_wr_en,
    input  logic               x_reg_wr_en,
    input  logic [4:0]         wb_dest,
    input  logic [2:0]         wb_nbeats,
    input  logic [VLANE_W-1:0] reg_wr_data,
    input  logic [VLANE_W-1:0] reg_wr_data_2,
    input  logic [VLANE_W-1:0] reg_wr_data_3,
    input  logic [VLANE_W-1:0] reg_wr_data_4,
    input  logic               vrf_wr_gnt,
    output logic               vrf_wr_en,
    output logic [4:0]         vrf_wr_addr,
    output logic [VLANE_W-1:0] vrf_wr_data,
    output logic               xrf_wr_en,
    output logic [4:0]         xrf_wr_addr,
    output logic [XLEN-1:0]    xrf_wr_data,
    output logic               wb_ready,
    output logic               wb_busy,
    output logic               wb_ovf,
    output logic [31:0]        wb_pending
);

    wb_state_e          r_state;
    wb_state_e          w_stateNext;
    logic [1:0]         r_beat;
    logic [1:0]         w_beatNext;
    logic               r_vPrev;
    logic               r_xPrev;
    logic               r_ovf;
    logic               r_xrfEn;
    logic [4:0]         r_xrfAddr;
    logic [XLEN-1:0]    r_xrfData;

    logic               w_vEdge;
    logic               w_xEdge;
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic               w_single;
    logic [2:0]         w_nbeatsClamped;
    wb_entry_t          w_pushEntry;
    wb_entry_t          w_head;
    logic [1:0]         w_lastBeat;
    logic               w_draining;
    logic               w_grant;
    logic [4:0]         w_vrfAddr;
    logic [VLANE_W-1:0] w_vrfData;
    logic [31:0]        w_pending;
    logic [VLANE_W-1:0] w_unusedData;

    // Only the scalar slice of beat 0 feeds the XRF path.
    assign w_unusedData = reg_wr_data >> XLEN;

    // -----------------------------------------------------------------------
    // Request edge detection and enqueue
    // -----------------------------------------------------------------------
    assign w_vEdge         = v_reg_wr_en & ~r_vPrev;
    assign w_xEdge         = x_reg_wr_en & ~r_xPrev;
    assign w_push          = w_vEdge & ~w_full;
    assign w_nbeatsClamped = clampNbeats(wb_nbeats);

    always_comb begin
        w_pushEntry         = '0;
        w_pushEntry.dest    = wb_dest;
        w_pushEntry.nbeats  = w_nbeatsClamped;
        w_pushEntry.data[0] = reg_wr_data;
        w_pushEntry.data[1] = reg_wr_data_2;
        w_pushEntry.data[2] = reg_wr_data_3;
        w_pushEntry.data[3] = reg_wr_data_4;
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_vPrev <= 1'b0;
            r_xPrev <= 1'b0;
        end else begin
            r_vPrev <= v_reg_wr_en;
            r_xPrev <= x_reg_wr_en;
        end
    end

    // Overflow is judged on the full flag before any same-cycle pop.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_ovf <= 1'b0;
        end else if (w_vEdge && w_full) begin
            r_ovf <= 1'b1;
        end
    end

    carrd_wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .nrst       (nrst),
        .i_push     (w_push),
        .i_pushData (w_pushEntry),
        .i_pop      (w_pop),
        .o_head     (w_head),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_single   (w_single)
    );

    // -----------------------------------------------------------------------
    // Drain FSM: walks the head entry one beat per grant
    // -----------------------------------------------------------------------
    assign w_draining = (r_state == ST_DRAIN);
    assign w_grant    = w_draining & vrf_wr_gnt;
    assign w_lastBeat = 2'(w_head.nbeats - 3'd1);
    assign w_vrfAddr  = 5'(w_head.dest + 5'(r_beat));
    assign w_vrfData  = w_head.data[r_beat];

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_state <= ST_IDLE;
            r_beat  <= 2'd0;
        end else begin
            r_state <= w_stateNext;
            r_beat  <= w_beatNext;
        end
    end

    // A same-cycle push keeps the FSM in DRAIN so the new entry follows
    // the popped one without an idle cycle.
    always_comb begin
        w_stateNext = r_state;
        w_beatNext  = r_beat;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_stateNext = ST_DRAIN;
                    w_beatNext  = 2'd0;
                end
            end
            ST_DRAIN: begin
                if (vrf_wr_gnt) begin
                    if (r_beat != w_lastBeat) begin
                        w_beatNext = r_beat + 2'd1;
                    end else begin
                        w_pop      = 1'b1;
                        w_beatNext = 2'd0;
                        if (w_single && !w_push) begin
                            w_stateNext = ST_IDLE;
                        end
                    end
                end
            end
            default: begin
                w_stateNext = ST_IDLE;
                w_beatNext  = 2'd0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Scalar path: one-cycle pulse, independent of the vector queue
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_xrfEn   <= 1'b0;
            r_xrfAddr <= 5'd0;
            r_xrfData <= '0;
        end else begin
            r_xrfEn <= w_xEdge;
            if (w_xEdge) begin
                r_xrfAddr <= wb_dest;
                r_xrfData <= reg_wr_data[XLEN-1:0];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Pending-write scoreboard
    // -----------------------------------------------------------------------
`ifdef CARRD_WB_PENDING_EN
    // One request never names the same register twice, so a register can
    // be owed at most FIFO_DEPTH writes; a counter per register survives
    // overlapping requests that a plain set/clear bit would not.
    localparam int PEND_W = $clog2(FIFO_DEPTH + 1);

    logic [PEND_W-1:0] r_pendCnt [32];
    logic [31:0]       w_pushMask;
    logic [31:0]       w_grantMask;

    always_comb begin
        w_pushMask  = '0;
        w_grantMask = '0;
        if (w_push) begin
            for (int i = 0; i < NBEATS_MAX; i++) begin
                if (i < int'(w_nbeatsClamped)) begin
                    w_pushMask[5'(wb_dest + 5'(i))] = 1'b1;
                end
            end
        end
        if (w_grant) begin
            w_grantMask[w_vrfAddr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            for (int r = 0; r < 32; r++) begin
                r_pendCnt[r] <= '0;
            end
        end else begin
            for (int r = 0; r < 32; r++) begin
                case ({w_pushMask[r], w_grantMask[r]})
                    2'b10:   r_pendCnt[r] <= r_pendCnt[r] + PEND_W'(1);
                    2'b01:   r_pendCnt[r] <= r_pendCnt[r] - PEND_W'(1);
                    default: r_pendCnt[r] <= r_pendCnt[r];
                endcase
            end
        end
    end

    always_comb begin
        w_pending = '0;
        for (int r = 0; r < 32; r++) begin
            w_pending[r] = (r_pendCnt[r] != '0);
        end
    end
`else
    assign w_pending = '0;
`endif

    // -----------------------------------------------------------------------
    // Outputs are forced to their idle values while reset is asserted
    // -----------------------------------------------------------------------
    assign vrf_wr_en   = nrst & w_draining;
    assign vrf_wr_addr = nrst ? w_vrfAddr : 5'd0;
    assign vrf_wr_data = nrst ? w_vrfData : '0;
    assign xrf_wr_en   = nrst & r_xrfEn;
    assign xrf_wr_addr = nrst ? r_xrfAddr : 5'd0;
    assign xrf_wr_data = nrst ? r_xrfData : '0;
    assign wb_ready    = ~nrst | ~w_full;
    assign wb_busy     = nrst & (~w_empty | w_draining);
    assign wb_ovf      = nrst & r_ovf;
    assign wb_pending  = nrst ? w_pending : 32'd0;

endmodule

// File: tb/tb_carrd_wb_sequencer.sv
// ---------------------------------------------------------------------------
// tb_carrd_wb_sequencer
// Directed, self-checking bench for carrd_wb_sequencer (FIFO_DEPTH=2,
// XLEN=32). Inputs change 1 time unit after a rising edge, so each
// observation after a tick reflects the state latched by that edge.
// ---------------------------------------------------------------------------
module tb_carrd_wb_sequencer;

    localparam int XLEN = 32;

    logic              clk;
    logic              nrst;
    logic              v_reg_wr_en;
    logic              x_reg_wr_en;
    logic [4:0]        wb_dest;
    logic [2:0]        wb_nbeats;
    logic [127:0]      reg_wr_data;
    logic [127:0]      reg_wr_data_2;
    logic [127:0]      reg_wr_data_3;
    logic [127:0]      reg_wr_data_4;
    logic              vrf_wr_gnt;
    logic              vrf_wr_en;
    logic [4:0]        vrf_wr_addr;
    logic [127:0]      vrf_wr_data;
    logic              xrf_wr_en;
    logic [4:0]        xrf_wr_addr;
    logic [XLEN-1:0]   xrf_wr_data;
    logic              wb_ready;
    logic              wb_busy;
    logic              wb_ovf;
    logic [31:0]       wb_pending;

    int compareCount  = 0;
    int mismatchCount = 0;

    carrd_wb_sequencer #(
        .FIFO_DEPTH (2),
        .XLEN       (XLEN)
    ) dut (
        .clk           (clk),
        .nrst          (nrst),
        .v_reg_wr_en   (v_reg_wr_en),
        .x_reg_wr_en   (x_reg_wr_en),
        .wb_dest       (wb_dest),
        .wb_nbeats     (wb_nbeats),
        .reg_wr_data   (reg_wr_data),
        .reg_wr_data_2 (reg_wr_data_2),
        .reg_wr_data_3 (reg_wr_data_3),
        .reg_wr_data_4 (reg_wr_data_4),
        .vrf_wr_gnt    (vrf_wr_gnt),
        .vrf_wr_en     (vrf_wr_en),
        .vrf_wr_addr   (vrf_wr_addr),
        .vrf_wr_data   (vrf_wr_data),
        .xrf_wr_en     (xrf_wr_en),
        .xrf_wr_addr   (xrf_wr_addr),
        .xrf_wr_data   (xrf_wr_data),
        .wb_ready      (wb_ready),
        .wb_busy       (wb_busy),
        .wb_ovf        (wb_ovf),
        .wb_pending    (wb_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just past the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Every comparison in the bench is routed through here.
    task automatic checkOutput(input string tag, input logic [127:0] actual,
                               input logic [127:0] expected);
        compareCount++;
        if (actual !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Distinct, recognisable pattern per request id and beat.
    function automatic logic [127:0] beatData(input logic [7:0] id, input int b);
        logic [7:0] bb;
        bb = 8'(b);
        return {id, bb, 16'h0000, 32'hFACE_0000, 32'h1234_5678, bb, id, 16'hBEEF};
    endfunction

    task automatic loadBeats(input logic [7:0] id);
        reg_wr_data   = beatData(id, 0);
        reg_wr_data_2 = beatData(id, 1);
        reg_wr_data_3 = beatData(id, 2);
        reg_wr_data_4 = beatData(id, 3);
    endtask

    task automatic scrambleBeats();
        reg_wr_data   = '1;
        reg_wr_data_2 = '1;
        reg_wr_data_3 = '1;
        reg_wr_data_4 = '1;
    endtask

    task automatic applyStimulus(input logic v, input logic x, input logic [4:0] dest,
                                 input logic [2:0] nbeats, input logic gnt);
        v_reg_wr_en = v;
        x_reg_wr_en = x;
        wb_dest     = dest;
        wb_nbeats   = nbeats;
        vrf_wr_gnt  = gnt;
    endtask

    // One-cycle v pulse; beat inputs are trashed afterwards so the queued
    // copy is what gets checked.
    task automatic sendRequest(input logic [7:0] id, input logic [4:0] dest,
                               input logic [2:0] nbeats);
        loadBeats(id);
        applyStimulus(1'b1, 1'b0, dest, nbeats, vrf_wr_gnt);
        tick();
        v_reg_wr_en = 1'b0;
        scrambleBeats();
    endtask

    // With grant held high, expect n consecutive beats then an idle port.
    task automatic expectBeats(input string tag, input logic [7:0] id,
                               input logic [4:0] dest, input int n);
        logic [4:0] addr;
        for (int b = 0; b < n; b++) begin
            tick();
            addr = 5'(dest + 5'(b));
            checkOutput($sformatf("%s_en%0d", tag, b), 128'(vrf_wr_en), 128'(1'b1));
            checkOutput($sformatf("%s_addr%0d", tag, b), 128'(vrf_wr_addr), 128'(addr));
            checkOutput($sformatf("%s_data%0d", tag, b), vrf_wr_data, beatData(id, b));
        end
        tick();
        checkOutput($sformatf("%s_done", tag), 128'(vrf_wr_en), 128'(1'b0));
    endtask

    initial begin
        int writes;
        int pulses;

        nrst = 1'b0;
        applyStimulus(1'b0, 1'b0, 5'd0, 3'd0, 1'b0);
        scrambleBeats();

        // ---------------- reset state ----------------
        tick();
        tick();
        checkOutput("rst_vrf_en",  128'(vrf_wr_en),   128'(1'b0));
        checkOutput("rst_vrf_addr",128'(vrf_wr_addr), 128'(0));
        checkOutput("rst_vrf_data",vrf_wr_data,       128'(0));
        checkOutput("rst_xrf_en",  128'(xrf_wr_en),   128'(1'b0));
        checkOutput("rst_xrf_data",128'(xrf_wr_data), 128'(0));
        checkOutput("rst_ready",   128'(wb_ready),    128'(1'b1));
        checkOutput("rst_busy",    128'(wb_busy),     128'(1'b0));
        checkOutput("rst_ovf",     128'(wb_ovf),      128'(1'b0));
        checkOutput("rst_pending", 128'(wb_pending),  128'(0));
        nrst = 1'b1;
        tick();

        // ---------------- dest=8, 4 beats, grant held ----------------
        vrf_wr_gnt = 1'b1;
        sendRequest(8'h01, 5'd8, 3'd4);
        checkOutput("t1_en_after_push", 128'(vrf_wr_en), 128'(1'b0));
        checkOutput("t1_busy",          128'(wb_busy),   128'(1'b1));
`ifdef CARRD_WB_PENDING_EN
        checkOutput("t1_pending", 128'(wb_pending), 128'(32'h0000_0F00));
`else
        checkOutput("t1_pending", 128'(wb_pending), 128'(0));
`endif
        expectBeats("t1", 8'h01, 5'd8, 4);
        checkOutput("t1_idle_busy", 128'(wb_busy), 128'(1'b0));

        // ---------------- held level, one beat ----------------
        writes = 0;
        loadBeats(8'h02);
        applyStimulus(1'b1, 1'b0, 5'd3, 3'd1, 1'b1);
        for (int i = 0; i < 6; i++) begin
            tick();
            if (vrf_wr_en) begin
                writes++;
                checkOutput("t2_addr", 128'(vrf_wr_addr), 128'(3));
            end
        end
        v_reg_wr_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (vrf_wr_en) writes++;
        end
        checkOutput("t2_write_count", 128'(writes), 128'(1));

        // ---------------- address wrap and beat-count clamping ----------------
        sendRequest(8'h03, 5'd30, 3'd4);
        expectBeats("t3_wrap", 8'h03, 5'd30, 4);
        sendRequest(8'h04, 5'd7, 3'd0);
        expectBeats("t3_zero", 8'h04, 5'd7, 1);
        sendRequest(8'h05, 5'd1, 3'd7);
        expectBeats("t3_seven", 8'h05, 5'd1, 4);

        // ---------------- grant stall on beat 1 ----------------
        sendRequest(8'h06, 5'd12, 3'd4);
        tick();
        checkOutput("t4_b0_addr", 128'(vrf_wr_addr), 128'(12));
        tick();
        checkOutput("t4_b1_addr", 128'(vrf_wr_addr), 128'(13));
        vrf_wr_gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput($sformatf("t4_stall_en%0d", i),   128'(vrf_wr_en),   128'(1'b1));
            checkOutput($sformatf("t4_stall_addr%0d", i), 128'(vrf_wr_addr), 128'(13));
            checkOutput($sformatf("t4_stall_data%0d", i), vrf_wr_data, beatData(8'h06, 1));
        end
        vrf_wr_gnt = 1'b1;
        tick();
        checkOutput("t4_b2_addr", 128'(vrf_wr_addr), 128'(14));
        checkOutput("t4_b2_data", vrf_wr_data, beatData(8'h06, 2));
        tick();
        checkOutput("t4_b3_addr", 128'(vrf_wr_addr), 128'(15));
        tick();
        checkOutput("t4_done", 128'(vrf_wr_en), 128'(1'b0));

        // ---------------- overflow with grant low ----------------
        loadBeats(8'h0A);
        applyStimulus(1'b1, 1'b0, 5'd20, 3'd1, 1'b0);
        tick();
        v_reg_wr_en = 1'b0;
        tick();
        checkOutput("t5_ready_one", 128'(wb_ready), 128'(1'b1));
        loadBeats(8'h0B);
        applyStimulus(1'b1, 1'b0, 5'd22, 3'd2, 1'b0);
        tick();
        checkOutput("t5_ready_full", 128'(wb_ready), 128'(1'b0));
        checkOutput("t5_ovf_before", 128'(wb_ovf),   128'(1'b0));
        v_reg_wr_en = 1'b0;
        tick();
        loadBeats(8'h0C);
        applyStimulus(1'b1, 1'b0, 5'd25, 3'd1, 1'b0);
        tick();
        checkOutput("t5_ovf_set",   128'(wb_ovf),      128'(1'b1));
        checkOutput("t5_ready_low", 128'(wb_ready),    128'(1'b0));
        checkOutput("t5_head_addr", 128'(vrf_wr_addr), 128'(20));
        checkOutput("t5_head_data", vrf_wr_data,       beatData(8'h0A, 0));
        v_reg_wr_en = 1'b0;
        scrambleBeats();
        vrf_wr_gnt  = 1'b1;
        tick();
        checkOutput("t5_b_en0",   128'(vrf_wr_en),   128'(1'b1));
        checkOutput("t5_b_addr0", 128'(vrf_wr_addr), 128'(22));
        checkOutput("t5_b_data0", vrf_wr_data,       beatData(8'h0B, 0));
        tick();
        checkOutput("t5_b_addr1", 128'(vrf_wr_addr), 128'(23));
        checkOutput("t5_b_data1", vrf_wr_data,       beatData(8'h0B, 1));
        tick();
        checkOutput("t5_done_en",   128'(vrf_wr_en), 128'(1'b0));
        checkOutput("t5_done_busy", 128'(wb_busy),   128'(1'b0));
        checkOutput("t5_done_ready",128'(wb_ready),  128'(1'b1));
        checkOutput("t5_ovf_sticky",128'(wb_ovf),    128'(1'b1));
        tick();
        checkOutput("t5_dropped_en", 128'(vrf_wr_en), 128'(1'b0));

        // ---------------- reset mid-drain ----------------
        sendRequest(8'h0D, 5'd16, 3'd4);
        tick();
        tick();
        tick();
        checkOutput("t6_b2_addr", 128'(vrf_wr_addr), 128'(18));
        nrst = 1'b0;
        tick();
        checkOutput("t6_rst_en",    128'(vrf_wr_en), 128'(1'b0));
        checkOutput("t6_rst_busy",  128'(wb_busy),   128'(1'b0));
        checkOutput("t6_rst_ovf",   128'(wb_ovf),    128'(1'b0));
        checkOutput("t6_rst_ready", 128'(wb_ready),  128'(1'b1));
        nrst = 1'b1;
        tick();
        checkOutput("t6_abandon_en0", 128'(vrf_wr_en), 128'(1'b0));
        tick();
        checkOutput("t6_abandon_en1", 128'(vrf_wr_en), 128'(1'b0));
        checkOutput("t6_abandon_busy",128'(wb_busy),   128'(1'b0));

        // ---------------- simultaneous v and x edges ----------------
        loadBeats(8'h0E);
        reg_wr_data = {96'h0123_4567_89AB_CDEF_0011_2233, 32'hDEAD_BEEF};
        applyStimulus(1'b1, 1'b1, 5'd5, 3'd1, 1'b1);
        tick();
        pulses = 0;
        if (xrf_wr_en) pulses++;
        checkOutput("t7_xrf_en",   128'(xrf_wr_en),   128'(1'b1));
        checkOutput("t7_xrf_addr", 128'(xrf_wr_addr), 128'(5));
        checkOutput("t7_xrf_data", 128'(xrf_wr_data), 128'(32'hDEAD_BEEF));
        checkOutput("t7_vrf_wait", 128'(vrf_wr_en),   128'(1'b0));
        tick();
        if (xrf_wr_en) pulses++;
        checkOutput("t7_xrf_off",  128'(xrf_wr_en),   128'(1'b0));
        checkOutput("t7_vrf_en",   128'(vrf_wr_en),   128'(1'b1));
        checkOutput("t7_vrf_addr", 128'(vrf_wr_addr), 128'(5));
        checkOutput("t7_vrf_data", vrf_wr_data,
                    {96'h0123_4567_89AB_CDEF_0011_2233, 32'hDEAD_BEEF});
        for (int i = 0; i < 4; i++) begin
            tick();
            if (xrf_wr_en) pulses++;
        end
        checkOutput("t7_xrf_pulses", 128'(pulses), 128'(1));
        checkOutput("t7_vrf_done",   128'(vrf_wr_en), 128'(1'b0));
        applyStimulus(1'b0, 1'b0, 5'd0, 3'd0, 1'b1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule

// File: doc/carrd_wb_sequencer.md
CARRD_WB_SEQUENCER -- requirements
Module: carrd_wb_sequencer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2, meaning the number of queued vector writeback requests (legal range 2..8).
REQ-002 SHALL have parameter XLEN, default 32, meaning the scalar register width.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port nrst, input, 1 bit, a synchronous active-low reset.
REQ-005 SHALL have port v_reg_wr_en, input, 1 bit, the vector writeback request level from the writeback stage.
REQ-006 SHALL have port x_reg_wr_en, input, 1 bit, the scalar writeback request level.
REQ-007 SHALL have port wb_dest, input, 5 bits, the base destination register index.
REQ-008 SHALL have port wb_nbeats, input, 3 bits, the valid 128-bit beats, 1..4; 0 is treated as 1 and 5..7 as 4.
REQ-009 SHALL have ports reg_wr_data, reg_wr_data_2, reg_wr_data_3 and reg_wr_data_4, each input, 128 bits, carrying beats 0..3.
REQ-010 SHALL have port vrf_wr_gnt, input, 1 bit, the VRF write-port accept.
REQ-011 SHALL have ports vrf_wr_en (output, 1), vrf_wr_addr (output, 5) and vrf_wr_data (output, 128), forming the VRF single-beat write port.
REQ-012 SHALL have ports xrf_wr_en (output, 1), xrf_wr_addr (output, 5) and xrf_wr_data (output, XLEN), forming the scalar write port.
REQ-013 SHALL have ports wb_ready, wb_busy and wb_ovf, each output, 1 bit: not full, any work pending, and sticky overflow.
REQ-014 SHALL have port wb_pending, output, 32 bits, the per-register pending-write mask (see Configuration).

Function
REQ-015 SHALL treat only a rising edge of v_reg_wr_en as a new request (high now, low the previous cycle); a held level SHALL NOT create duplicates.
REQ-016 SHALL push {wb_dest, clamped nbeats, 4 data beats} into the FIFO on an accepted edge when wb_ready=1.
REQ-017 SHALL drive wb_ready = FIFO not full (combinational); an edge arriving while full SHALL be dropped and set wb_ovf, even if a pop occurs in the same cycle.
REQ-018 SHALL implement an FSM with states IDLE and DRAIN, plus a 2-bit beat counter.
REQ-019 In IDLE with the FIFO non-empty, SHALL enter DRAIN with beat=0; a request pushed into an empty FIFO at edge N SHALL show vrf_wr_en=1 at N+1.
REQ-020 In DRAIN, SHALL drive vrf_wr_en=1, vrf_wr_addr=(dest+beat) mod 32 and vrf_wr_data=the selected beat, all held stable until vrf_wr_gnt=1.
REQ-021 On grant of a non-final beat, SHALL increment beat, so beats issue back-to-back when the grant is held high.
REQ-022 On grant of the final beat, SHALL pop the FIFO; if the FIFO is still non-empty, SHALL stay in DRAIN with beat=0 (no bubble), otherwise SHALL return to IDLE with vrf_wr_en=0 the next cycle.
REQ-023 On a rising edge of x_reg_wr_en, SHALL pulse xrf_wr_en for exactly one cycle next cycle, with xrf_wr_addr=wb_dest and xrf_wr_data=reg_wr_data[XLEN-1:0]; this path is unqueued and independent of the vector path.
REQ-024 SHALL accept simultaneous v and x edges on both paths.
REQ-025 SHALL drive wb_busy = FIFO non-empty OR state==DRAIN.

Reset
REQ-026 On nrst=0 at a clock edge, SHALL clear the FIFO, the FSM (to IDLE), the beat counter, the edge-detect flops and wb_ovf.
REQ-027 During reset, SHALL drive vrf_wr_en, xrf_wr_en, wb_busy and wb_pending to 0, all address and data outputs to 0, and wb_ready to 1.
REQ-028 A reset mid-DRAIN SHALL abandon the remaining beats without completing them.

Configuration
REQ-029 With CARRD_WB_PENDING_EN defined, wb_pending bit r SHALL be 1 while any queued or in-flight request has a not-yet-granted beat targeting register r; bits SHALL set on push and clear on the grant of that beat.
REQ-030 Without CARRD_WB_PENDING_EN, wb_pending SHALL be tied to 0 and no scoreboard logic SHALL be synthesized.

Structure
REQ-031 The shared package carrd_pkg SHALL hold the FSM state enum, the FIFO entry struct, and the constants VLANE_W=128 and NBEATS_MAX=4.
REQ-032 The FIFO SHALL be a sub-module named carrd_wb_fifo, a parameterized sync FIFO with push, pop, full and empty.

Verification
REQ-033 The bench SHALL cover: v edge with dest=8, nbeats=4, gnt held 1 -> vrf_wr_en on cycles N+1..N+4 with addr 8,9,10,11 and the matching beats.
REQ-034 The bench SHALL cover: v_reg_wr_en held high 6 cycles, nbeats=1 -> exactly one VRF write.
REQ-035 The bench SHALL cover: dest=30, nbeats=4 -> addr sequence 30,31,0,1.
REQ-036 The bench SHALL cover: gnt=0 for 3 cycles mid-beat 1 -> addr and data stable, beat 2 only after gnt.
REQ-037 The bench SHALL cover: three v edges with gnt=0 (FIFO_DEPTH=2) -> third dropped, wb_ready=0, wb_ovf=1; two requests complete after gnt returns.
REQ-038 The bench SHALL cover: nrst=0 during beat 2 of 4 -> vrf_wr_en=0, wb_busy=0 and wb_ovf=0 after the edge; simultaneous x edge with dest=5 and data=0xDEADBEEF -> single xrf pulse, addr 5.
